multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  in  1  synchronous reset, active-high.
REQ-003 Op_i  in  6  opcode of the instruction register (IR[31:26]), sampled in DECODE.
REQ-004 mem_ready_i  in  1  memory access completes this cycle.
REQ-005 PCWrite_o / PCWriteCond_o  out  1 each  unconditional / beq-qualified PC update.
REQ-006 IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-007 MemRead_o / MemWrite_o / IRWrite_o  out  1 each  memory strobes and IR load.
REQ-008 MemtoReg_o / RegWrite_o / RegDst_o  out  1 each  register-file writeback controls.
REQ-009 ALUSrcA_o  out  1, ALUSrcB_o  out  2, ALUOp_o  out  2  ALU operand and operation selects.
REQ-010 PCSource_o  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-011 state_o  out  4  current state encoding, for debug.
REQ-012 illegal_o  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-013 Moore FSM; every output except the IRWrite_o/PCWrite_o gating in REQ-015 is a function of state only; all unlisted outputs are 0 in each state.
REQ-014 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready_i; stays in FETCH until mem_ready_i, then goes to DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX (only if configured)
  - any other opcode -> FETCH, with illegal_o=1 registered for exactly one cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; goes to MEMRD for lw, MEMWR for sw (opcode held from DECODE in an internal register).
REQ-018 MEMRD: MemRead=1, IorD=1; waits for mem_ready_i, then goes to MEMWB.
REQ-019 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; goes to FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; waits for mem_ready_i, then goes to FETCH.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; goes to ALUWB.
REQ-022 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; goes to FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; goes to FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10; goes to FETCH.
REQ-025 Cycle counts with mem_ready_i tied high: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4; each memory wait cycle adds exactly one cycle.
REQ-026 MemRead_o and MemWrite_o are never both 1; they are held stable throughout a wait.
REQ-027 A mem_ready_i pulse in any non-waiting state is ignored.
REQ-028 An unused state encoding goes to FETCH on the next edge, with illegal_o pulsed.

Reset
REQ-029 When rst_i=1 at a clock edge: state becomes FETCH, the internal opcode register becomes 0, and illegal_o becomes 0.
REQ-030 Reset asserted mid-operation (including during a memory wait) aborts the instruction; no write strobe is issued after the reset edge.
REQ-031 Out of reset, FETCH outputs appear in the first cycle: MemRead_o=1, and PCWrite_o=IRWrite_o=0 unless mem_ready_i=1.

Configuration
REQ-032 Macro MULTICYCLE_ADDI_EN.
  - Defined: opcode 001000 goes to ADDIEX (ALUSrcA=1, ALUSrcB=10, ALUOp=00), then ADDIWB (RegWrite=1, RegDst=0, MemtoReg=0), then FETCH.
  - Undefined: opcode 001000 is illegal per REQ-016, and states 10 and 11 are unused per REQ-028.

Structure
REQ-033 A shared package holds the opcode constants (OP_LW, OP_SW, OP_BEQ, OP_RTYPE, OP_J, OP_ADDI), the state encodings, and the ALUOp/PCSource/ALUSrcB codes.
REQ-034 One sub-module, multicycle_ctrl_decode, performs the combinational state-to-output mapping; the top level holds the state and opcode registers and the next-state logic.

Verification
REQ-035 Reset, then lw (Op_i=100011) with mem_ready_i high -> states 0,1,2,3,4,0; RegWrite_o=1 and MemtoReg_o=1 only in state 4.
REQ-036 sw with mem_ready_i low for 3 cycles in MEMWR -> MemWrite_o=1 for 4 cycles with IorD_o=1; then FETCH.
REQ-037 beq, then j -> PCWriteCond_o=1 in state 8 with PCSource_o=01; PCWrite_o=1 in state 9 with PCSource_o=10.
REQ-038 Op_i=111111 in DECODE -> illegal_o=1 for one cycle, then FETCH; no write strobes.
REQ-039 rst_i asserted in MEMRD while mem_ready_i is low -> next cycle state_o=0, MemRead_o=1, IorD_o=0.
REQ-040 Op_i=001000 with MULTICYCLE_ADDI_EN -> states 0,1,10,11,0; without the macro -> illegal_o pulse.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcodes, state encodings, select codes and the control-word layout for multicycle_ctrl.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control mapping; only FETCH looks at mem_ready to gate IR/PC load.
// Optional ADDI states are decoded when MULTICYCLE_ADDI_EN is defined.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath; outputs follow state in the same cycle and the
// FSM stalls in FETCH/MEMRD/MEMWR until mem_ready_i. MULTICYCLE_ADDI_EN adds the addi path.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d = Op_i;
        case (Op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`else
          OP_ADDI:      illegal_d = 1'b1;
`endif
          default:      illegal_d = 1'b1;
        endcase
      end
      // Only lw and sw reach MEMADR, so the held opcode just picks read vs write.
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`endif
      default:  illegal_d = 1'b1;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready_i),
    .ctrl      (ctrl)
  );

  assign PCWrite_o     = ctrl.pc_write;
  assign PCWriteCond_o = ctrl.pc_write_cond;
  assign IorD_o        = ctrl.iord;
  assign MemRead_o     = ctrl.mem_read;
  assign MemWrite_o    = ctrl.mem_write;
  assign IRWrite_o     = ctrl.ir_write;
  assign MemtoReg_o    = ctrl.mem_to_reg;
  assign RegWrite_o    = ctrl.reg_write;
  assign RegDst_o      = ctrl.reg_dst;
  assign ALUSrcA_o     = ctrl.alu_src_a;
  assign ALUSrcB_o     = ctrl.alu_src_b;
  assign ALUOp_o       = ctrl.alu_op;
  assign PCSource_o    = ctrl.pc_source;
  assign state_o       = state_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level model of state paths and per-state control table.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] Op_i = '0;
  logic       mem_ready_i = 1'b0;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic       MemtoReg_o, RegWrite_o, RegDst_o, ALUSrcA_o, illegal_o;
  logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
  logic [3:0] state_o;
  logic [15:0] act_ctrl;

  int   checks = 0;
  int   errors = 0;
  logic pend_ill = 1'b0;
  int   memwr_cycles = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .Op_i          (Op_i),
    .mem_ready_i   (mem_ready_i),
    .PCWrite_o     (PCWrite_o),
    .PCWriteCond_o (PCWriteCond_o),
    .IorD_o        (IorD_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .IRWrite_o     (IRWrite_o),
    .MemtoReg_o    (MemtoReg_o),
    .RegWrite_o    (RegWrite_o),
    .RegDst_o      (RegDst_o),
    .ALUSrcA_o     (ALUSrcA_o),
    .ALUSrcB_o     (ALUSrcB_o),
    .ALUOp_o       (ALUOp_o),
    .PCSource_o    (PCSource_o),
    .state_o       (state_o),
    .illegal_o     (illegal_o)
  );

  assign act_ctrl = {MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o, PCWriteCond_o,
                     RegWrite_o, MemtoReg_o, RegDst_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o};

  // Expected control word per state, straight from the control table.
  function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
    logic mrd, mwr, iord, irw, pcw, pcwc, rw, m2r, rdst, sa;
    logic [1:0] sb, aop, pcs;
    {mrd, mwr, iord, irw, pcw, pcwc, rw, m2r, rdst, sa} = '0;
    sb = 2'd0; aop = 2'd0; pcs = 2'd0;
    case (s)
      0:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mwr = 1'b1; iord = 1'b1; end
      6:  begin sa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rdst = 1'b1; end
      8:  begin sa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
`ifdef MULTICYCLE_ADDI_EN
      10: begin sa = 1'b1; sb = 2'b10; end
      11: rw = 1'b1;
`endif
      default: ;
    endcase
    return {mrd, mwr, iord, irw, pcw, pcwc, rw, m2r, rdst, sa, sb, aop, pcs};
  endfunction

  // Runs one instruction: fw wait cycles in FETCH, mw wait cycles in the memory state.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
    int   seq[$];
    int   path[$];
    logic mrs[$];
    logic ill;
    int   w;
    ill = 1'b0;
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 9};
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: seq = '{0, 1, 10, 11};
`endif
      default: begin seq = '{0, 1}; ill = 1'b1; end
    endcase
    foreach (seq[k]) begin
      if (seq[k] == 0 || seq[k] == 3 || seq[k] == 5) begin
        w = (seq[k] == 0) ? fw : mw;
        for (int j = 0; j < w; j++) begin path.push_back(seq[k]); mrs.push_back(1'b0); end
        path.push_back(seq[k]); mrs.push_back(1'b1);
      end else begin
        path.push_back(seq[k]); mrs.push_back(1'($urandom));
      end
    end
    for (int i = 0; i < path.size(); i++) begin
      @(negedge clk_i);
      mem_ready_i = mrs[i];
      Op_i = (path[i] == 1) ? op : 6'($urandom);
      #1;
      checks++;
      if (state_o !== 4'(path[i])) begin
        errors++;
        $display("FAIL %s state cyc%0d: got %0d want %0d", tag, i, state_o, path[i]);
      end
      checks++;
      if (act_ctrl !== exp_ctrl(path[i], mrs[i])) begin
        errors++;
        $display("FAIL %s ctrl cyc%0d st%0d: got %b want %b", tag, i, path[i], act_ctrl,
                 exp_ctrl(path[i], mrs[i]));
      end
      checks++;
      if (illegal_o !== ((i == 0) ? pend_ill : 1'b0)) begin
        errors++;
        $display("FAIL %s illegal cyc%0d: got %b want %b", tag, i, illegal_o,
                 (i == 0) ? pend_ill : 1'b0);
      end
      if (MemWrite_o === 1'b1) memwr_cycles++;
    end
    pend_ill = ill;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_ready_i = 1'b0; Op_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL reset state/illegal: got %0d/%b want 0/0", state_o, illegal_o);
    end
    checks++;
    if (act_ctrl !== exp_ctrl(0, 1'b0)) begin
      errors++;
      $display("FAIL reset ctrl ready0: got %b want %b", act_ctrl, exp_ctrl(0, 1'b0));
    end
    mem_ready_i = 1'b1;
    #1;
    checks++;
    if (IRWrite_o !== 1'b1 || PCWrite_o !== 1'b1 || MemRead_o !== 1'b1) begin
      errors++;
      $display("FAIL reset ready1 IRWrite/PCWrite/MemRead: got %b%b%b want 111",
               IRWrite_o, PCWrite_o, MemRead_o);
    end
    mem_ready_i = 1'b0;
    pend_ill = 1'b0;
  endtask

  // Assert reset in the second wait cycle of the memory state ws (3 = MEMRD, 5 = MEMWR).
  task automatic test_reset_mid(input logic [5:0] op, input int ws, input string tag);
    int path[5];
    path = '{0, 1, 2, ws, ws};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      mem_ready_i = (path[i] == 0);
      Op_i = (path[i] == 1) ? op : 6'($urandom);
      rst_i = (i == 4);
      #1;
      checks++;
      if (state_o !== 4'(path[i])) begin
        errors++;
        $display("FAIL %s pre-reset state cyc%0d: got %0d want %0d", tag, i, state_o, path[i]);
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || MemRead_o !== 1'b1 || IorD_o !== 1'b0 || MemWrite_o !== 1'b0 ||
        illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL %s post-reset: state=%0d rd=%b iord=%b wr=%b ill=%b want 0,1,0,0,0",
               tag, state_o, MemRead_o, IorD_o, MemWrite_o, illegal_o);
    end
    pend_ill = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 0, 0, "lw");
  endtask

  task automatic test_sw_wait();
    memwr_cycles = 0;
    run_instr(6'b101011, 0, 3, "sw_wait");
    checks++;
    if (memwr_cycles != 4) begin
      errors++;
      $display("FAIL sw_wait MemWrite cycles: got %0d want 4", memwr_cycles);
    end
  endtask

  task automatic test_branch_jump();
    run_instr(6'b000100, 0, 0, "beq");
    run_instr(6'b000010, 0, 0, "j");
    run_instr(6'b000000, 1, 0, "rtype");
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(6'b100011, 2, 1, "after_illegal");
  endtask

  task automatic test_addi();
    run_instr(6'b001000, 0, 0, "addi");
    run_instr(6'b000100, 0, 0, "after_addi");
  endtask

  task automatic test_back_to_back();
    logic [5:0] op;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), "random");
    end
    run_instr(6'b000010, 0, 0, "final");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch_jump();
    test_illegal();
    test_addi();
    test_reset_mid(6'b100011, 3, "rst_memrd");
    test_reset_mid(6'b101011, 5, "rst_memwr");
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
